final_cpa_pipe: RTL

//  Pipelined final carry-propagate adder of the multiplier: converts the compression tree's
//  sum/carry vectors into a binary product. Generates bitwise G/P, then runs a registered

---
 rtl/final_cpa_pipe.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/final_cpa_pipe.sv
// final_cpa_pipe -- pipelined final carry-propagate adder of the multiplier.
// Turns the compression tree's sum/carry vectors into a binary result using a
// Kogge-Stone prefix network that is split across two register stages.
//   S0: bitwise generate/propagate (carry-in folded into bit 0)
//   S1: G/P after SPLIT_LEVEL prefix levels, plus the half-sum
//   S2: final sum (and carry-out)
// Valid/ready handshakes are used on both sides. Every stage loads when it is
// empty or when it hands its contents forward in the same cycle, so bubbles
// collapse.
// Optional feature macro: FINAL_CPA_COUT_EN adds the out_cout port and its register.

module final_cpa_pipe #(
  parameter int WIDTH       = 68,
  parameter int SPLIT_LEVEL = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum
`ifdef FINAL_CPA_COUT_EN
  ,
  output logic             out_cout
`endif
);

  localparam int LEVELS = $clog2(WIDTH);
`ifdef FINAL_CPA_COUT_EN
  localparam int GW = WIDTH;      // top group-generate is the carry-out
`else
  localparam int GW = WIDTH - 1;  // top group-generate feeds nothing
`endif

  // Kogge-Stone prefix levels lvl_lo..lvl_hi (1-based, span 2^(k-1)); returns {G, P}.
  function automatic logic [2*WIDTH-1:0] ks_levels(
    input logic [WIDTH-1:0] g_in,
    input logic [WIDTH-1:0] p_in,
    input int               lvl_lo,
    input int               lvl_hi
  );
    logic [WIDTH-1:0] g_cur;
    logic [WIDTH-1:0] p_cur;
    logic [WIDTH-1:0] g_nxt;
    logic [WIDTH-1:0] p_nxt;
    int               span;
    g_cur = g_in;
    p_cur = p_in;
    for (int k = 1; k <= LEVELS; k++) begin
      span = 32'sd1 << (k - 1);
      g_nxt = g_cur;
      p_nxt = p_cur;
      if ((k >= lvl_lo) && (k <= lvl_hi)) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (i >= span) begin
            g_nxt[i] = g_cur[i] | (p_cur[i] & g_cur[i-span]);
            p_nxt[i] = p_cur[i] & p_cur[i-span];
          end else begin
            g_nxt[i] = g_cur[i];
            p_nxt[i] = p_cur[i];
          end
        end
      end else begin
        g_nxt = g_cur;
        p_nxt = p_cur;
      end
      g_cur = g_nxt;
      p_cur = p_nxt;
    end
    return {g_cur, p_cur};
  endfunction

  // Stage registers
  logic             v0_r, v1_r, v2_r;
  logic [WIDTH-1:0] g0_r, p0_r;
  logic             cin0_r;
  logic [WIDTH-1:0] g1_r, p1_r, h1_r;
  logic             cin1_r;
  logic [WIDTH-1:0] sum2_r;
`ifdef FINAL_CPA_COUT_EN
  logic             cout2_r;
`endif

  // Combinational datapath / handshake signals
  logic             move0_s, move1_s, move2_s;
  logic             load1_s, load2_s;
  logic [WIDTH-1:0] g_in_s, p_in_s;
  logic [WIDTH-1:0] g_mid_s, p_mid_s;
  logic [GW-1:0]    g_fin_s;
  logic [WIDTH-1:0] sum_s;

  // Back-pressure chain: each stage may load if empty or if it moves on this cycle.
  always_comb begin
    move2_s  = v2_r & out_ready;
    load2_s  = ~v2_r | move2_s;
    move1_s  = v1_r & load2_s;
    load1_s  = ~v1_r | move1_s;
    move0_s  = v0_r & load1_s;
    in_ready = ~v0_r | move0_s;
  end

  // Bitwise generate/propagate; carry-in folded into the bit-0 generate.
  always_comb begin
    p_in_s    = in_a ^ in_b;
    g_in_s    = in_a & in_b;
    g_in_s[0] = (in_a[0] & in_b[0]) | (p_in_s[0] & in_cin);
  end

  // Prefix levels on both sides of the mid register, then the sum bits.
  always_comb begin
    {g_mid_s, p_mid_s} = ks_levels(g0_r, p0_r, 1, SPLIT_LEVEL);
    g_fin_s = GW'(ks_levels(g1_r, p1_r, SPLIT_LEVEL + 1, LEVELS) >> WIDTH);
    sum_s   = h1_r ^ {g_fin_s[WIDTH-2:0], cin1_r};
  end

  // S0: capture G/P of an accepted operand pair.
  always_ff @(posedge clock) begin
    if (reset) begin
      v0_r   <= 1'b0;
      g0_r   <= {WIDTH{1'b0}};
      p0_r   <= {WIDTH{1'b0}};
      cin0_r <= 1'b0;
    end else if (in_ready) begin
      v0_r <= in_valid;
      if (in_valid) begin
        g0_r   <= g_in_s;
        p0_r   <= p_in_s;
        cin0_r <= in_cin;
      end
    end
  end

  // S1: partial prefix result; the half-sum equals the S0 propagate vector.
  always_ff @(posedge clock) begin
    if (reset) begin
      v1_r   <= 1'b0;
      g1_r   <= {WIDTH{1'b0}};
      p1_r   <= {WIDTH{1'b0}};
      h1_r   <= {WIDTH{1'b0}};
      cin1_r <= 1'b0;
    end else if (load1_s) begin
      v1_r <= v0_r;
      if (v0_r) begin
        g1_r   <= g_mid_s;
        p1_r   <= p_mid_s;
        h1_r   <= p0_r;
        cin1_r <= cin0_r;
      end
    end
  end

  // S2: output register; held unchanged while the consumer stalls.
  always_ff @(posedge clock) begin
    if (reset) begin
      v2_r    <= 1'b0;
      sum2_r  <= {WIDTH{1'b0}};
`ifdef FINAL_CPA_COUT_EN
      cout2_r <= 1'b0;
`endif
    end else if (load2_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        sum2_r  <= sum_s;
`ifdef FINAL_CPA_COUT_EN
        cout2_r <= g_fin_s[GW-1];
`endif
      end
    end
  end

  assign out_valid = v2_r;
  assign out_sum   = sum2_r;
`ifdef FINAL_CPA_COUT_EN
  assign out_cout  = cout2_r;
`endif

endmodule
